// File: rtl/if_id_buffer_pkg.sv
// Shared constants and types for the IF/ID elastic buffer.
//   InstAddrBus : instruction address bus width
//   NopInst     : bubble instruction (addi x0, x0, 0)
//   RstEnable   : level of rst_n that holds the block in reset
//   occ_e       : buffer occupancy (number of held entries)
package if_id_buffer_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam logic [31:0] NopInst     = 32'h0000_0013;
    localparam logic        RstEnable   = 1'b0;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry elastic buffer between fetch and decode.
// Holds up to two {pc, inst} entries in FIFO order. Outputs come straight
// from the head slot registers; in_ready depends only on registered occupancy.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : fetch-side handshake
//   in_pc, in_inst      : fetched entry
//   flush               : drop all held entries and the current input
//   out_valid/out_ready : decode-side handshake
//   out_pc, out_inst    : head entry (out_inst = NOP_INST when empty)
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned PC_W     = InstAddrBus,
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst
);

    occ_e            count_q, count_d;
    logic [PC_W-1:0] head_pc_q, head_pc_d;
    logic [31:0]     head_inst_q, head_inst_d;
    logic [PC_W-1:0] tail_pc_q, tail_pc_d;
    logic [31:0]     tail_inst_q, tail_inst_d;

    logic push;
    logic pop;

    assign in_ready  = (count_q != OccFull);
    assign out_valid = (count_q != OccEmpty);
    assign out_pc    = head_pc_q;
    assign out_inst  = head_inst_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        count_d     = count_q;
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        tail_pc_d   = tail_pc_q;
        tail_inst_d = tail_inst_q;

        if (flush) begin
            // out_pc deliberately keeps its last value; only the instruction is bubbled.
            count_d     = OccEmpty;
            head_inst_d = NOP_INST;
        end else begin
            case (count_q)
                OccEmpty: begin
                    if (push) begin
                        head_pc_d   = in_pc;
                        head_inst_d = in_inst;
                        count_d     = OccOne;
                    end
                end
                OccOne: begin
                    if (push && pop) begin
                        head_pc_d   = in_pc;
                        head_inst_d = in_inst;
                    end else if (push) begin
                        tail_pc_d   = in_pc;
                        tail_inst_d = in_inst;
                        count_d     = OccFull;
                    end else if (pop) begin
                        head_inst_d = NOP_INST;
                        count_d     = OccEmpty;
                    end
                end
                OccFull: begin
                    // push cannot happen here: in_ready is low.
                    if (pop) begin
                        head_pc_d   = tail_pc_q;
                        head_inst_d = tail_inst_q;
                        count_d     = OccOne;
                    end
                end
                default: begin
                    count_d     = OccEmpty;
                    head_inst_d = NOP_INST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RstEnable) begin
            count_q     <= OccEmpty;
            head_pc_q   <= '0;
            head_inst_q <= NOP_INST;
            tail_pc_q   <= '0;
            tail_inst_q <= '0;
        end else begin
            count_q     <= count_d;
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
            tail_pc_q   <= tail_pc_d;
            tail_inst_q <= tail_inst_d;
        end
    end

endmodule
